// File: rtl/stats_seq_ctrl.sv
// Sequencer feeding an external 8-bit ALU to compute max/min/avg over N streamed samples.
// Optional STATS_SUM_SAT_EN: running sum saturates at 8'hFF instead of wrapping.
module stats_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        n_cnt,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_op_A,
  output logic [DATA_W-1:0] alu_op_B,
  output logic [1:0]        alu_select,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_remainder,
  input  logic              alu_sign_flag,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] avg_out,
  output logic [DATA_W-1:0] avg_rem,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err,
  output logic [3:0]        state_dbg
);

  // Stream handshake: a sample transfers on a rising CLK edge where in_valid && in_ready;
  // in_ready is high only in WAIT_IN and in_valid is ignored in every other state.

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_IN, S_ADD_I, S_ADD_W, S_MAX_I, S_MAX_W,
    S_MIN_I, S_MIN_W, S_DIV_I, S_DIV_W, S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam logic [DATA_W-1:0] MIN_INIT = {1'b0, {(DATA_W-1){1'b1}}};

  state_t state, state_nx;

  logic [7:0]        n_r;
  logic [7:0]        k;
  logic [7:0]        k_inc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] max_r;
  logic [DATA_W-1:0] min_r;
  logic [DATA_W-1:0] sample_r;
  logic [DATA_W-1:0] op_a_nx;
  logic [DATA_W-1:0] op_b_nx;
  logic [1:0]        sel_nx;
  logic              bad_n;
  logic              sum_wrap;

  assign k_inc    = k + 8'd1;
  assign bad_n    = (n_cnt == 8'd0) || (int'(n_cnt) > MAX_N);
  assign sum_wrap = (alu_out < acc);

  assign in_ready  = (state == S_WAIT_IN);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = bad_n ? S_DONE : S_WAIT_IN;
      S_WAIT_IN: if (in_valid) state_nx = in_data[DATA_W-1] ? S_DONE : S_ADD_I;
      S_ADD_I:   state_nx = S_ADD_W;
      S_ADD_W:   state_nx = S_MAX_I;
      S_MAX_I:   state_nx = S_MAX_W;
      S_MAX_W:   state_nx = S_MIN_I;
      S_MIN_I:   state_nx = S_MIN_W;
      S_MIN_W:   state_nx = (k_inc == n_r) ? S_DIV_I : S_WAIT_IN;
      S_DIV_I:   state_nx = S_DIV_W;
      S_DIV_W:   state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // ALU operands are registered: they are chosen from the state being entered.
  always_comb begin
    op_a_nx = alu_op_A;
    op_b_nx = alu_op_B;
    sel_nx  = OP_NOP;
    case (state_nx)
      S_ADD_I, S_ADD_W: sel_nx = OP_ADD;
      S_MAX_I, S_MAX_W,
      S_MIN_I, S_MIN_W: sel_nx = OP_SUB;
      S_DIV_I, S_DIV_W: sel_nx = OP_DIV;
      default:          sel_nx = OP_NOP;
    endcase
    if (state_nx == S_ADD_I && state != S_ADD_I) begin
      op_a_nx = acc;
      op_b_nx = in_data;
    end
    if (state_nx == S_MAX_I && state != S_MAX_I) begin
      op_a_nx = sample_r;
      op_b_nx = max_r;
    end
    if (state_nx == S_MIN_I && state != S_MIN_I) begin
      op_a_nx = sample_r;
      op_b_nx = min_r;
    end
    if (state_nx == S_DIV_I && state != S_DIV_I) begin
      op_a_nx = acc;
      op_b_nx = n_r;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_op_A   <= '0;
      alu_op_B   <= '0;
      alu_select <= OP_NOP;
    end else begin
      alu_op_A   <= op_a_nx;
      alu_op_B   <= op_b_nx;
      alu_select <= sel_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      n_r      <= '0;
      k        <= '0;
      acc      <= '0;
      max_r    <= '0;
      min_r    <= MIN_INIT;
      sample_r <= '0;
      max_out  <= '0;
      min_out  <= '0;
      avg_out  <= '0;
      avg_rem  <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            max_out <= '0;
            min_out <= '0;
            avg_out <= '0;
            avg_rem <= '0;
            ovf     <= 1'b0;
            err     <= bad_n;
            n_r     <= n_cnt;
            k       <= '0;
            acc     <= '0;
            max_r   <= '0;
            min_r   <= MIN_INIT;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            sample_r <= in_data;
            if (in_data[DATA_W-1]) err <= 1'b1;
          end
        end
        S_ADD_W: begin
          if (sum_wrap) ovf <= 1'b1;
`ifdef STATS_SUM_SAT_EN
          // ovf already set means acc is pinned at all-ones for the rest of the run
          acc <= (sum_wrap || ovf) ? '1 : alu_out;
`else
          acc <= alu_out;
`endif
        end
        S_MAX_W: begin
          if (!alu_sign_flag && alu_out != '0) max_r <= sample_r;
        end
        S_MIN_W: begin
          if (alu_sign_flag) min_r <= sample_r;
          k <= k_inc;
        end
        S_DIV_W: begin
          avg_out <= alu_out;
          avg_rem <= alu_remainder;
          max_out <= max_r;
          min_out <= min_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stats_seq_ctrl.sv
// Bench for stats_seq_ctrl: behavioural ALU, directed spec cases, randomized runs vs. an arithmetic model.
module tb_stats_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] n_cnt;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_op_A, alu_op_B;
  logic [1:0] alu_select;
  logic [7:0] alu_out = 8'd0;
  logic [7:0] alu_remainder = 8'd0;
  logic       alu_sign_flag = 1'b0;
  logic [7:0] max_out, min_out, avg_out, avg_rem;
  logic       busy, done, ovf, err;
  logic [3:0] state_dbg;

  stats_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .n_cnt(n_cnt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op_A(alu_op_A), .alu_op_B(alu_op_B), .alu_select(alu_select),
    .alu_out(alu_out), .alu_remainder(alu_remainder), .alu_sign_flag(alu_sign_flag),
    .max_out(max_out), .min_out(min_out), .avg_out(avg_out), .avg_rem(avg_rem),
    .busy(busy), .done(done), .ovf(ovf), .err(err), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // Behavioural 8-bit ALU: registers a result every edge its select is not NOP.
  always @(posedge CLK) begin
    case (alu_select)
      2'b00: begin alu_out <= alu_op_A + alu_op_B; alu_sign_flag <= 1'b0; end
      2'b01: begin alu_out <= alu_op_A - alu_op_B; alu_sign_flag <= (alu_op_A < alu_op_B); end
      2'b10: if (alu_op_B != 8'd0) begin
               alu_out <= alu_op_A / alu_op_B;
               alu_remainder <= alu_op_A % alu_op_B;
             end
      default: ;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Edge monitor: counts done pulses and DIV issue cycles.
  int cyc = 0;
  int done_cnt = 0;
  int div_cnt = 0;
  int last_div_cyc = -1;
  always @(posedge CLK) begin
    cyc++;
    if (!RST && done) done_cnt++;
    if (!RST && alu_select == 2'b10) begin
      div_cnt++;
      last_div_cyc = cyc;
      check_eq("div_b_nonzero", {31'd0, alu_op_B != 8'd0}, 32'd1);
    end
  end

  logic [7:0] smp [0:63];

  // Runs one start/feed/done sequence and checks the results against plain arithmetic.
  task automatic run_case(input int n, input int n_feed, input string tag);
    int sum, acc_v, waited, gap, base_done;
    logic [7:0] e_max, e_min, e_avg, e_rem;
    bit bad, e_ovf;
    bad = (n == 0);
    sum = 0; e_max = 8'd0; e_min = 8'd127;
    for (int i = 0; i < n_feed; i++) begin
      if (smp[i][7]) bad = 1'b1;
      else begin
        sum += int'(smp[i]);
        if (smp[i] > e_max) e_max = smp[i];
        if (smp[i] < e_min) e_min = smp[i];
      end
    end
    e_ovf = (sum > 255);
`ifdef STATS_SUM_SAT_EN
    acc_v = (sum > 255) ? 255 : sum;
`else
    acc_v = sum % 256;
`endif
    if (bad) begin
      e_max = 8'd0; e_min = 8'd0; e_avg = 8'd0; e_rem = 8'd0;
    end else begin
      e_avg = 8'(acc_v / n);
      e_rem = 8'(acc_v % n);
    end

    base_done = done_cnt;
    div_cnt = 0;
    @(negedge CLK); start = 1'b1; n_cnt = 8'(n);
    @(negedge CLK); start = 1'b0; n_cnt = 8'($urandom);
    for (int i = 0; i < n_feed; i++) begin
      waited = 0;
      while (!in_ready && waited < 40) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
        @(negedge CLK);
        waited++;
      end
      in_valid = 1'b0;
      if (waited >= 40) begin
        check_eq({tag, "_ready_timeout"}, 32'(waited), 32'd0);
        return;
      end
      check_eq({tag, "_ready_latency"}, 32'(waited), (i == 0) ? 32'd0 : 32'd6);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge CLK);
      in_valid = 1'b1; in_data = smp[i];
      @(negedge CLK);
      in_valid = 1'b0; in_data = 8'($urandom);
    end
    waited = 0;
    while (!done && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check_eq({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (n == 0) check_eq({tag, "_done_latency"}, 32'(waited), 32'd0);
    check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err}, {31'd0, bad});
    check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    check_eq({tag, "_max"}, {24'd0, max_out}, {24'd0, e_max});
    check_eq({tag, "_min"}, {24'd0, min_out}, {24'd0, e_min});
    check_eq({tag, "_avg"}, {24'd0, avg_out}, {24'd0, e_avg});
    check_eq({tag, "_rem"}, {24'd0, avg_rem}, {24'd0, e_rem});
    check_eq({tag, "_div_cycles"}, 32'(div_cnt), bad ? 32'd0 : 32'd2);
    if (!bad) check_eq({tag, "_done_after_div"}, 32'(cyc - last_div_cyc), 32'd0);
    @(negedge CLK);
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_done_count"}, 32'(done_cnt - base_done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nf, dc;
    RST = 1'b1; start = 1'b0; n_cnt = 8'd0; in_data = 8'd0; in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_select", {30'd0, alu_select}, 32'd3);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_flags", {30'd0, ovf, err}, 32'd0);
    check_eq("rst_results", {max_out, min_out, avg_out, avg_rem}, 32'd0);
    RST = 1'b0;

    // start with in_valid high while idle must not consume anything
    @(negedge CLK); in_valid = 1'b1; in_data = 8'd99;
    @(negedge CLK); in_valid = 1'b0;
    check_eq("idle_valid_ignored", {31'd0, busy}, 32'd0);

    smp[0] = 8'd10; smp[1] = 8'd50; smp[2] = 8'd30;
    run_case(3, 3, "basic");
    smp[0] = 8'd7; smp[1] = 8'd8;
    run_case(2, 2, "rem");
    smp[0] = 8'd100; smp[1] = 8'd100; smp[2] = 8'd100;
    run_case(3, 3, "overflow");
    run_case(0, 0, "n_zero");
    smp[0] = 8'd20; smp[1] = 8'h80;
    run_case(3, 2, "bad_sample");
    smp[0] = 8'd5;
    run_case(1, 1, "single");
    for (int i = 0; i < 4; i++) smp[i] = 8'd127;
    run_case(4, 4, "all_max");

    for (int r = 0; r < 14; r++) begin
      n = $urandom_range(1, 12);
      nf = n;
      for (int i = 0; i < n; i++) smp[i] = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 5) == 0) begin
        nf = $urandom_range(1, n);
        smp[nf-1] = smp[nf-1] | 8'h80;
      end
      run_case(n, nf, $sformatf("rand%0d", r));
    end

    // Reset during MAX_W: run must vanish with no done pulse.
    smp[0] = 8'd40; smp[1] = 8'd60;
    run_case(2, 2, "pre_rst");
    dc = done_cnt;
    @(negedge CLK); start = 1'b1; n_cnt = 8'd3;
    @(negedge CLK); start = 1'b0;
    in_valid = 1'b1; in_data = 8'd33;
    @(negedge CLK); in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("mid_select_sub", {30'd0, alu_select}, 32'd1);
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("mid_rst_select", {30'd0, alu_select}, 32'd3);
    check_eq("mid_rst_results", {max_out, min_out, avg_out, avg_rem}, 32'd0);
    check_eq("mid_rst_flags", {29'd0, ovf, err, done}, 32'd0);
    repeat (20) @(negedge CLK);
    check_eq("mid_rst_no_done", 32'(done_cnt - dc), 32'd0);

    smp[0] = 8'd9; smp[1] = 8'd3;
    run_case(2, 2, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
